// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester block-RAM arbiter.
// Holds the FSM state encoding, the requester side codes and the latched
// operation codes used by bram_arbiter2 and rr_arb2.
package bram_arb_pkg;

    localparam int unsigned WMASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage : bram_arb_pkg

// File: rtl/bram_arbiter2_rr_arb2.sv
// Combinational two-way round-robin picker.
// Ports: req_a/req_b requests, last_grant side served last;
//        gnt_valid any request present, gnt_side chosen side.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_side
);

    // On a tie the side that was not served last wins.
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_side  = SIDE_A;
        if (req_a && req_b) begin
            gnt_side = ~last_grant;
        end else if (req_b) begin
            gnt_side = SIDE_B;
        end
    end

endmodule : rr_arb2

// File: rtl/bram_arbiter2.sv
// Two-requester arbiter in front of one single-port block RAM with a
// registered read (one-cycle latency). Each grant runs IDLE -> GRANT -> DONE,
// then pulses the winner's ack; reads also update that side's rdata.
// Ports: clk, resetn (async, active-low);
//        a_*/b_* requester interfaces (cs, rd, wr, addr, wdata, wmask in;
//        ack, rdata out); mem_* RAM interface (cs, rd, wr, addr, wdata,
//        wmask out; rdata in).
module bram_arbiter2
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               a_cs,
    input  logic               a_rd,
    input  logic               a_wr,
    input  logic [AW-1:0]      a_addr,
    input  logic [DW-1:0]      a_wdata,
    input  logic [WMASK_W-1:0] a_wmask,
    output logic               a_ack,
    output logic [DW-1:0]      a_rdata,
    input  logic               b_cs,
    input  logic               b_rd,
    input  logic               b_wr,
    input  logic [AW-1:0]      b_addr,
    input  logic [DW-1:0]      b_wdata,
    input  logic [WMASK_W-1:0] b_wmask,
    output logic               b_ack,
    output logic [DW-1:0]      b_rdata,
    output logic               mem_cs,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic [DW-1:0]      mem_rdata
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               side_q, side_d;
    logic               op_q, op_d;
    logic               mem_cs_q, mem_cs_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic [WMASK_W-1:0] mem_wmask_q, mem_wmask_d;
    logic               a_ack_q, a_ack_d;
    logic               b_ack_q, b_ack_d;
    logic [DW-1:0]      a_rdata_q, a_rdata_d;
    logic [DW-1:0]      b_rdata_q, b_rdata_d;

    logic req_a, req_b, gnt_valid, gnt_side;

    // cs with neither rd nor wr is not a request.
    assign req_a = a_cs & (a_rd | a_wr);
    assign req_b = b_cs & (b_rd | b_wr);

    rr_arb2 u_rr_arb2 (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_side   (gnt_side)
    );

    // Next-state and output decode. The mem_* registers double as the
    // request latch: loaded on the IDLE decision, visible during GRANT.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        side_d       = side_q;
        op_d         = op_q;
        mem_cs_d     = mem_cs_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    side_d       = gnt_side;
                    last_grant_d = gnt_side;
                    mem_cs_d     = 1'b1;
                    if (gnt_side == SIDE_A) begin
                        op_d        = a_wr ? OP_WR : OP_RD;
                        mem_addr_d  = a_addr;
                        mem_wdata_d = a_wdata;
                        mem_wmask_d = a_wmask;
                    end else begin
                        op_d        = b_wr ? OP_WR : OP_RD;
                        mem_addr_d  = b_addr;
                        mem_wdata_d = b_wdata;
                        mem_wmask_d = b_wmask;
                    end
                    mem_wr_d = (op_d == OP_WR);
                    mem_rd_d = (op_d == OP_RD);
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                mem_cs_d    = 1'b0;
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b0;
                mem_addr_d  = AW'(0);
                mem_wdata_d = DW'(0);
                mem_wmask_d = WMASK_W'(0);
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                // mem_rdata is valid now, one cycle after the RAM sampled.
                if (side_q == SIDE_A) begin
                    a_ack_d = 1'b1;
                    if (op_q == OP_RD) a_rdata_d = mem_rdata;
                end else begin
                    b_ack_d = 1'b1;
                    if (op_q == OP_RD) b_rdata_d = mem_rdata;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SIDE_B;
            side_q       <= SIDE_A;
            op_q         <= OP_RD;
            mem_cs_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= AW'(0);
            mem_wdata_q  <= DW'(0);
            mem_wmask_q  <= WMASK_W'(0);
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= DW'(0);
            b_rdata_q    <= DW'(0);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            side_q       <= side_d;
            op_q         <= op_d;
            mem_cs_q     <= mem_cs_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign mem_cs    = mem_cs_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule : bram_arbiter2
